// File: rtl/card_pkg.sv
// Shared types and constants for the card game sequencer.
package card_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_WRITE,
      ST_TURN,
      ST_DONE
   } state_t;

   localparam logic [3:0] KEY_P0_DONE = 4'b0011;
   localparam logic [3:0] KEY_P1_DONE = 4'b0001;

   localparam int unsigned RND_W    = 5;
   localparam int unsigned COLOR_W  = 2;
   localparam int unsigned NUMBER_W = 3;

   localparam logic [2:0] HAND_MAX = 3'd7;

endpackage

// File: rtl/card_map.sv
// Maps a 5-bit random value onto a card color (1..3) and number (1..5).
module card_map
   import card_pkg::*;
(
   input  logic [RND_W-1:0]    i_rnd,
   output logic [COLOR_W-1:0]  o_color,
   output logic [NUMBER_W-1:0] o_number
);

   // Fold the upper two bits onto 1..3 and the lower three onto 1..5.
   always_comb begin
      o_color  = 2'd1;
      o_number = 3'd1;
      case (i_rnd[4:3])
         2'b00:   o_color = 2'd1;
         2'b01:   o_color = 2'd2;
         2'b10:   o_color = 2'd3;
         default: o_color = 2'd1;
      endcase
      case (i_rnd[2:0])
         3'd0:    o_number = 3'd1;
         3'd1:    o_number = 3'd2;
         3'd2:    o_number = 3'd3;
         3'd3:    o_number = 3'd4;
         3'd4:    o_number = 3'd5;
         3'd5:    o_number = 3'd1;
         3'd6:    o_number = 3'd2;
         default: o_number = 3'd3;
      endcase
   end

endmodule

// File: rtl/card_deal_ctrl.sv
// Two-player card game sequencer: initial deal, turn changes, draws, game end.
module card_deal_ctrl
   import card_pkg::*;
#(
   parameter int unsigned HAND_SIZE = 5,
   parameter logic [7:0]  MAX_TURNS = 8'd200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       rnd_req,
   input  logic [4:0] rnd_in,
   output logic       deal_valid,
   output logic       deal_player,
   output logic [2:0] deal_slot,
   output logic [1:0] deal_color,
   output logic [2:0] deal_number,
   output logic       whose,
   output logic [7:0] turn_count,
   output logic       busy,
   output logic       game_over
);

   localparam logic [3:0] DEAL_TOTAL = 4'(2 * HAND_SIZE);

   state_t      r_state, w_next_state;
   logic        r_initial;
   logic [3:0]  r_deal_cnt;
   logic [2:0]  r_hand0, r_hand1;
   logic        r_whose;
   logic [7:0]  r_turns;
   logic        r_deal_player;
   logic [2:0]  r_deal_slot;
   logic [1:0]  r_deal_color;
   logic [2:0]  r_deal_number;

   logic        w_start_ok, w_key_ok, w_target;
   logic [2:0]  w_target_cnt, w_incoming_cnt;
   logic [7:0]  w_turns_inc;
   logic [1:0]  w_color;
   logic [2:0]  w_number;

   card_map u_map (
      .i_rnd    (rnd_in),
      .o_color  (w_color),
      .o_number (w_number)
   );

   assign w_start_ok     = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
   assign w_key_ok       = (r_state == ST_TURN) & key_valid &
                           (((key_code == KEY_P0_DONE) & ~r_whose) |
                            ((key_code == KEY_P1_DONE) &  r_whose));
   assign w_turns_inc    = r_turns + 8'd1;
   assign w_incoming_cnt = r_whose ? r_hand0 : r_hand1;
   assign w_target       = r_initial ? r_deal_cnt[0] : r_whose;
   assign w_target_cnt   = w_target ? r_hand1 : r_hand0;

   assign whose       = r_whose;
   assign turn_count  = r_turns;
   assign deal_player = r_deal_player;
   assign deal_slot   = r_deal_slot;
   assign deal_color  = r_deal_color;
   assign deal_number = r_deal_number;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state selection and state-decoded strobes.
   always_comb begin
      w_next_state = r_state;
      rnd_req      = 1'b0;
      deal_valid   = 1'b0;
      busy         = 1'b1;
      game_over    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) w_next_state = ST_REQ;
         end
         ST_REQ: begin
            rnd_req      = 1'b1;
            w_next_state = ST_WAIT;
         end
         ST_WAIT: w_next_state = ST_WRITE;
         ST_WRITE: begin
            deal_valid = 1'b1;
            if (r_initial && (r_deal_cnt != DEAL_TOTAL - 4'd1)) w_next_state = ST_REQ;
            else                                                 w_next_state = ST_TURN;
         end
         ST_TURN: begin
            if (w_key_ok) begin
               if (w_turns_inc == MAX_TURNS)        w_next_state = ST_DONE;
               else if (w_incoming_cnt != HAND_MAX) w_next_state = ST_REQ;
               else                                 w_next_state = ST_TURN;
            end
         end
         ST_DONE: begin
            busy      = 1'b0;
            game_over = 1'b1;
            if (start) w_next_state = ST_REQ;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Game bookkeeping and the registered deal record.
   // The mapped card is captured in WAIT rather than the raw rnd, so deal_* read 0 after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_initial     <= 1'b0;
         r_deal_cnt    <= '0;
         r_hand0       <= '0;
         r_hand1       <= '0;
         r_whose       <= 1'b0;
         r_turns       <= '0;
         r_deal_player <= 1'b0;
         r_deal_slot   <= '0;
         r_deal_color  <= '0;
         r_deal_number <= '0;
      end else begin
         if (w_start_ok) begin
            r_initial  <= 1'b1;
            r_deal_cnt <= '0;
            r_hand0    <= '0;
            r_hand1    <= '0;
            r_whose    <= 1'b0;
            r_turns    <= '0;
         end
         if (r_state == ST_WAIT) begin
            r_deal_player <= w_target;
            r_deal_slot   <= w_target_cnt;
            r_deal_color  <= w_color;
            r_deal_number <= w_number;
         end
         if (r_state == ST_WRITE) begin
            if (!r_deal_player && (r_hand0 != HAND_MAX)) r_hand0 <= r_hand0 + 3'd1;
            if ( r_deal_player && (r_hand1 != HAND_MAX)) r_hand1 <= r_hand1 + 3'd1;
            if (r_initial) r_deal_cnt <= r_deal_cnt + 4'd1;
         end
         if (w_key_ok) begin
            r_whose   <= ~r_whose;
            r_turns   <= w_turns_inc;
            r_initial <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_card_deal_ctrl.sv
// Self-checking bench for card_deal_ctrl: directed table, corner sequences, random play.
module tb_card_deal_ctrl;

   localparam int HS = 2;
   localparam int MT = 20;

   logic       clk = 1'b0;
   logic       rst, start, key_valid, start_b, key_valid_b;
   logic [3:0] key_code;
   logic [4:0] rnd_in;
   logic       rnd_req, deal_valid, deal_player, whose, busy, game_over;
   logic [2:0] deal_slot, deal_number;
   logic [1:0] deal_color;
   logic [7:0] turn_count;
   logic       b_rnd_req, b_deal_valid, b_deal_player, b_whose, b_busy, b_game_over;
   logic [2:0] b_deal_slot, b_deal_number;
   logic [1:0] b_deal_color;
   logic [7:0] b_turn_count;

   always #5 clk = ~clk;

   card_deal_ctrl #(.HAND_SIZE(HS), .MAX_TURNS(8'(MT))) dut (
      .clk(clk), .rst(rst), .start(start), .key_valid(key_valid), .key_code(key_code),
      .rnd_req(rnd_req), .rnd_in(rnd_in), .deal_valid(deal_valid), .deal_player(deal_player),
      .deal_slot(deal_slot), .deal_color(deal_color), .deal_number(deal_number),
      .whose(whose), .turn_count(turn_count), .busy(busy), .game_over(game_over)
   );

   card_deal_ctrl #(.HAND_SIZE(1), .MAX_TURNS(8'd3)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .key_valid(key_valid_b), .key_code(key_code),
      .rnd_req(b_rnd_req), .rnd_in(rnd_in), .deal_valid(b_deal_valid), .deal_player(b_deal_player),
      .deal_slot(b_deal_slot), .deal_color(b_deal_color), .deal_number(b_deal_number),
      .whose(b_whose), .turn_count(b_turn_count), .busy(b_busy), .game_over(b_game_over)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int b_strobes = 0;

   // Reference model: a game is a sequence of 3-cycle card bursts starting after a trigger cycle.
   int  m_cyc, m_bN, m_blen, m_turns;
   bit  m_game, m_done, m_init, m_whose;
   int  m_cnt[2];
   bit  m_lp, m_pp;
   int  m_ls, m_lc, m_ln, m_ps, m_pc, m_pn;
   logic [4:0] rnd_q[$];

   typedef struct {
      bit         st;
      logic [3:0] kc;
      logic [4:0] rnd;
      bit         pl;
      int         slot, col, num, lat;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, m_cyc);
      end
   endtask

   function automatic int card_color(input int v);
      return ((v / 8) % 3) + 1;
   endfunction

   function automatic int card_number(input int v);
      return ((v % 8) % 5) + 1;
   endfunction

   function automatic bit in_burst();
      return m_game && (m_cyc >= m_bN + 1) && (m_cyc < m_bN + 1 + 3 * m_blen);
   endfunction

   function automatic bit in_turn();
      return m_game && !m_done && (m_cyc >= m_bN + 1 + 3 * m_blen);
   endfunction

   task automatic model_clear();
      m_game = 0; m_done = 0; m_init = 0; m_whose = 0; m_turns = 0;
      m_bN = 0; m_blen = 0; m_cnt[0] = 0; m_cnt[1] = 0;
      m_lp = 0; m_ls = 0; m_lc = 0; m_ln = 0;
   endtask

   // Check the current cycle against the model, drive this cycle's inputs, advance the model.
   task automatic tick(input bit st, input bit kv, input logic [3:0] kc, input bit rs);
      int j, p;
      bit burst;
      logic [4:0] v;
      burst = in_burst();
      j = m_cyc - m_bN - 1;
      if (burst && (j % 3 == 2)) begin
         m_lp = m_pp; m_ls = m_ps; m_lc = m_pc; m_ln = m_pn;
      end
      chk("rnd_req", rnd_req, burst && (j % 3 == 0));
      chk("deal_valid", deal_valid, burst && (j % 3 == 2));
      chk("busy", busy, m_game && !m_done);
      chk("game_over", game_over, m_done);
      chk("whose", whose, m_whose);
      chk("turn_count", turn_count, m_turns);
      chk("deal_player", deal_player, m_lp);
      chk("deal_slot", deal_slot, m_ls);
      chk("deal_color", deal_color, m_lc);
      chk("deal_number", deal_number, m_ln);
      if (b_deal_valid === 1'b1) b_strobes++;

      start = st; key_valid = kv; key_code = kc; rst = rs;
      if (burst && (j % 3 == 1)) begin
         v = (rnd_q.size() > 0) ? rnd_q.pop_front() : 5'($urandom);
         rnd_in = v;
         p = m_init ? ((j / 3) % 2) : int'(m_whose);
         m_pp = p[0]; m_ps = m_cnt[p]; m_pc = card_color(v); m_pn = card_number(v);
         if (m_cnt[p] < 7) m_cnt[p]++;
      end else begin
         rnd_in = 5'($urandom);
      end

      if (rs) begin
         model_clear();
      end else if (st && !(m_game && !m_done)) begin
         m_game = 1; m_done = 0; m_whose = 0; m_turns = 0;
         m_cnt[0] = 0; m_cnt[1] = 0;
         m_bN = m_cyc; m_blen = 2 * HS; m_init = 1;
      end else if (kv && in_turn() &&
                   (((kc == 4'b0011) && !m_whose) || ((kc == 4'b0001) && m_whose))) begin
         m_whose = !m_whose;
         m_turns++;
         if (m_turns == MT) m_done = 1;
         else if (m_cnt[m_whose ? 1 : 0] < 7) begin
            m_bN = m_cyc; m_blen = 1; m_init = 0;
         end
      end
      m_cyc++;
      @(negedge clk);
   endtask

   task automatic wait_turn();
      for (int t = 0; t < 60 && !in_turn(); t++) tick(0, 0, 4'h0, 0);
   endtask

   task automatic wait_strobe();
      for (int t = 0; t < 30 && deal_valid !== 1'b1; t++) tick(0, 0, 4'h0, 0);
      chk("strobe_seen", deal_valid, 1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rnd_req"}, rnd_req, 0);
      chk({tag, "_deal_valid"}, deal_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_game_over"}, game_over, 0);
      chk({tag, "_whose"}, whose, 0);
      chk({tag, "_turn_count"}, turn_count, 0);
      chk({tag, "_deal_fields"}, {deal_player, deal_slot, deal_color, deal_number}, 0);
   endtask

   initial begin
      int ts;
      bit full;
      logic [3:0] kc;
      tbl[0] = '{1'b1, 4'h0,    5'b11100, 1'b0, 0, 1, 5, 3};
      tbl[1] = '{1'b0, 4'h0,    5'b01010, 1'b1, 0, 2, 3, 6};
      tbl[2] = '{1'b0, 4'h0,    5'b11100, 1'b0, 1, 1, 5, 9};
      tbl[3] = '{1'b0, 4'h0,    5'b01010, 1'b1, 1, 2, 3, 12};
      tbl[4] = '{1'b0, 4'b0011, 5'b00101, 1'b1, 2, 1, 1, 3};
      tbl[5] = '{1'b0, 4'b0001, 5'b10111, 1'b0, 2, 3, 3, 3};

      rst = 1; start = 0; key_valid = 0; key_code = 0; rnd_in = 0;
      start_b = 0; key_valid_b = 0;
      repeat (3) @(negedge clk);
      model_clear();
      m_cyc = 0;
      chk_zero("reset");

      // Initial deal, wrong-player key, turn changes with draws.
      for (int i = 0; i < 6; i++) rnd_q.push_back(tbl[i].rnd);
      ts = 0;
      for (int i = 0; i < 6; i++) begin
         if (tbl[i].st) begin
            ts = m_cyc;
            tick(1, 0, 4'h0, 0);
         end else if (tbl[i].kc != 4'h0) begin
            wait_turn();
            tick(0, 1, (tbl[i].kc == 4'b0011) ? 4'b0001 : 4'b0011, 0);
            chk("wrong_key_whose", whose, (tbl[i].kc == 4'b0011) ? 0 : 1);
            chk("wrong_key_turns", turn_count, i - 4);
            ts = m_cyc;
            tick(0, 1, tbl[i].kc, 0);
            chk("key_whose", whose, (tbl[i].kc == 4'b0011) ? 1 : 0);
            chk("key_turns", turn_count, i - 3);
         end
         wait_strobe();
         chk("tbl_latency", m_cyc - ts, tbl[i].lat);
         chk("tbl_player", deal_player, tbl[i].pl);
         chk("tbl_slot", deal_slot, tbl[i].slot);
         chk("tbl_color", deal_color, tbl[i].col);
         chk("tbl_number", deal_number, tbl[i].num);
         tick(0, 0, 4'h0, 0);
      end

      // Play on until both hands are full; a change to a full player draws nothing.
      for (int g = 0; g < 20 && m_turns < 12; g++) begin
         wait_turn();
         full = (m_cnt[m_whose ? 0 : 1] >= 7);
         tick(0, 1, m_whose ? 4'b0001 : 4'b0011, 0);
         if (full) begin
            for (int t = 0; t < 4; t++) begin
               chk("full_no_req", rnd_req, 0);
               chk("full_no_strobe", deal_valid, 0);
               tick(0, 0, 4'h0, 0);
            end
         end
      end
      chk("full_turns", turn_count, 12);
      chk("full_whose", whose, 0);
      chk("last_draw_player", deal_player, 0);
      chk("last_draw_slot", deal_slot, 6);

      // Start while busy is ignored.
      tick(1, 0, 4'h0, 0);
      chk("start_busy_turns", turn_count, 12);
      chk("start_busy_busy", busy, 1);

      // Reset in TURN, then reset mid-deal, then a clean restart from slot 0.
      tick(0, 0, 4'h0, 1);
      chk_zero("rst_turn");
      tick(1, 0, 4'h0, 0);
      for (int s = 0; s < 3; s++) begin
         wait_strobe();
         tick(0, 0, 4'h0, 0);
      end
      tick(0, 0, 4'h0, 1);
      chk_zero("rst_deal");
      ts = m_cyc;
      tick(1, 0, 4'h0, 0);
      wait_strobe();
      chk("restart_latency", m_cyc - ts, 3);
      chk("restart_player", deal_player, 0);
      chk("restart_slot", deal_slot, 0);

      // Game end on the second instance (one card each, three turns).
      b_strobes = 0;
      start_b = 1; tick(0, 0, 4'h0, 0); start_b = 0;
      repeat (7) tick(0, 0, 4'h0, 0);
      chk("b_turn_whose", b_whose, 0);
      chk("b_turn_busy", b_busy, 1);
      for (int k = 0; k < 3; k++) begin
         key_valid_b = 1;
         tick(0, 0, (k % 2 == 0) ? 4'b0011 : 4'b0001, 0);
         key_valid_b = 0;
         chk("b_turns", b_turn_count, k + 1);
         repeat (4) tick(0, 0, 4'h0, 0);
      end
      chk("b_game_over", b_game_over, 1);
      chk("b_done_busy", b_busy, 0);
      chk("b_done_turns", b_turn_count, 3);
      chk("b_done_whose", b_whose, 1);
      chk("b_strobes", b_strobes, 4);
      key_valid_b = 1; tick(0, 0, 4'b0001, 0); key_valid_b = 0;
      chk("b_key_after_done", b_turn_count, 3);
      chk("b_still_over", b_game_over, 1);
      start_b = 1; tick(0, 0, 4'h0, 0); start_b = 0;
      chk("b_restart_turns", b_turn_count, 0);
      chk("b_restart_over", b_game_over, 0);
      chk("b_restart_busy", b_busy, 1);
      chk("b_restart_whose", b_whose, 0);

      // Random play against the model.
      for (int n = 0; n < 3000; n++) begin
         case ($urandom % 4)
            0:       kc = 4'b0011;
            1:       kc = 4'b0001;
            2:       kc = 4'($urandom);
            default: kc = m_whose ? 4'b0001 : 4'b0011;
         endcase
         tick(($urandom % 50) == 0, ($urandom % 3) == 0, kc, ($urandom % 500) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
